// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings plus the memory tester's mode, state and LFSR helpers.
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HALF  = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [1:0] MODE_ADDR  = 2'd0;
    localparam logic [1:0] MODE_LFSR  = 2'd1;
    localparam logic [1:0] MODE_WALK  = 2'd2;
    localparam logic [1:0] MODE_NADDR = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WRITE  = 3'd1,
        ST_WFLUSH = 3'd2,
        ST_READ   = 3'd3,
        ST_RFLUSH = 3'd4,
        ST_DONE   = 3'd5
    } tester_state_e;

    // Right-shifting Galois masks for maximal-length sequences.
    function automatic logic [63:0] lfsr_taps(input int dw);
        case (dw)
            8:       return 64'h0000_0000_0000_00B8;
            16:      return 64'h0000_0000_0000_B400;
            32:      return 64'h0000_0000_8020_0003;
            default: return 64'hD800_0000_0000_0000;
        endcase
    endfunction

    function automatic logic [2:0] hsize_for(input int dw);
        case (dw)
            8:       return HSIZE_BYTE;
            16:      return HSIZE_HALF;
            32:      return HSIZE_WORD;
            default: return HSIZE_DWORD;
        endcase
    endfunction

    // An all-zero LFSR state would lock up, so a seed that truncates to zero becomes 1.
    function automatic logic [63:0] seed_fit(input logic [31:0] seed, input int dw);
        logic [63:0] s;
        s = {seed, seed};
        if (dw < 64) s = s & ((64'd1 << dw) - 64'd1);
        if (s == 64'd0) s = 64'd1;
        return s;
    endfunction

endpackage

// File: rtl/ahb_lite_pattern_gen.sv
// Data pattern source shared by the write and read passes; the read pass
// reloads the seed so it regenerates exactly what was written.
module ahb_lite_pattern_gen
    import ahb_lite_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] LFSR_SEED  = 32'hACE1_1234
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic                          restart,
    input  logic                          advance,
    input  logic [1:0]                    mode,
    input  logic [$clog2(DATA_WIDTH)-1:0] index,
    input  logic [ADDR_WIDTH-1:0]         addr,
    output logic [DATA_WIDTH-1:0]         pattern
);

    localparam logic [DATA_WIDTH-1:0] TAPS = DATA_WIDTH'(lfsr_taps(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] SEED = DATA_WIDTH'(seed_fit(LFSR_SEED, DATA_WIDTH));

    logic [DATA_WIDTH-1:0] lfsr_q;
    logic [DATA_WIDTH-1:0] addr_word;
    logic [DATA_WIDTH-1:0] one_hot;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            lfsr_q <= SEED;
        end else if (restart) begin
            lfsr_q <= SEED;
        end else if (advance) begin
            lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
        end
    end

    always_comb begin
        addr_word = DATA_WIDTH'(addr);
        one_hot   = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << index;
        pattern   = addr_word;
        case (mode)
            MODE_ADDR:  pattern = addr_word;
            MODE_LFSR:  pattern = lfsr_q;
            MODE_WALK:  pattern = one_hot;
            MODE_NADDR: pattern = ~addr_word;
            default:    pattern = addr_word;
        endcase
    end

endmodule

// File: rtl/ahb_lite_mem_tester.sv
// AHB-Lite single-master fill-and-verify engine: one write pass, one read-back
// pass, pipelined NONSEQ singles, error count and first failing address.
module ahb_lite_mem_tester
    import ahb_lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    WORD_COUNT = 1024,
    parameter logic [31:0]           LFSR_SEED  = 32'hACE1_1234,
    parameter int                    ERR_WIDTH  = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  start,
    input  logic [1:0]            mode,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [2:0]            HBURST,
    output logic                  HSEL,
    output logic [2:0]            HSIZE,
    output logic [1:0]            HTRANS,
    output logic [DATA_WIDTH-1:0] HWDATA,
    output logic                  HWRITE,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP,
    output logic [2:0]            dbg_state
);

    localparam int                    BYTES    = DATA_WIDTH / 8;
    localparam int                    IDX_W    = 21;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(WORD_COUNT - 1);
    localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(BYTES);
    localparam logic [63:0]           END_ADDR = 64'(BASE_ADDR) + 64'(WORD_COUNT) * 64'(BYTES);

    if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_width
        $error("ahb_lite_mem_tester: DATA_WIDTH must be 8, 16, 32 or 64");
    end
    if (WORD_COUNT < 1 || WORD_COUNT > (1 << 20)) begin : g_bad_count
        $error("ahb_lite_mem_tester: WORD_COUNT out of range");
    end
    if (64'(BASE_ADDR) % 64'(BYTES) != 64'd0) begin : g_bad_align
        $error("ahb_lite_mem_tester: BASE_ADDR not word aligned");
    end
    if (ADDR_WIDTH < 64 && END_ADDR > (64'd1 << ADDR_WIDTH)) begin : g_bad_wrap
        $error("ahb_lite_mem_tester: address range overflows ADDR_WIDTH");
    end

    tester_state_e state_q, state_d;

    logic [IDX_W-1:0]      idx_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] hwdata_q;
    logic [DATA_WIDTH-1:0] exp_data_q;
    logic                  dp_valid_q;
    logic                  dp_write_q;
    logic [ADDR_WIDTH-1:0] dp_addr_q;
    logic [ERR_WIDTH-1:0]  err_q;
    logic [ADDR_WIDTH-1:0] first_q;
    logic [1:0]            mode_q;
    logic [DATA_WIDTH-1:0] pattern;

    logic start_ok, addr_phase, addr_accept, last_word, wflush_done, dp_done, dp_bad;

    // Handshake: an address phase (HTRANS=NONSEQ) is taken and a data phase
    // completes only on a cycle with HREADY=1; while HREADY=0 every master
    // output (HADDR/HTRANS/HWRITE/HWDATA) holds and nothing in flight moves.
    always_comb begin
        start_ok    = start && (state_q == ST_IDLE || state_q == ST_DONE);
        addr_phase  = (state_q == ST_WRITE) || (state_q == ST_READ);
        addr_accept = addr_phase && HREADY;
        last_word   = (idx_q == LAST_IDX);
        wflush_done = (state_q == ST_WFLUSH) && HREADY;
        dp_done     = dp_valid_q && HREADY;
        dp_bad      = (HRESP == HRESP_ERROR) || (!dp_write_q && (HRDATA != exp_data_q));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start)                    state_d = ST_WRITE;
            ST_WRITE:         if (addr_accept && last_word) state_d = ST_WFLUSH;
            ST_WFLUSH:        if (HREADY)                   state_d = ST_READ;
            ST_READ:          if (addr_accept && last_word) state_d = ST_RFLUSH;
            ST_RFLUSH:        if (HREADY)                   state_d = ST_DONE;
            default:                                        state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            idx_q      <= '0;
            addr_q     <= '0;
            hwdata_q   <= '0;
            exp_data_q <= '0;
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= '0;
            err_q      <= '0;
            first_q    <= '0;
            mode_q     <= MODE_ADDR;
        end else if (start_ok) begin
            idx_q      <= '0;
            addr_q     <= BASE_ADDR;
            dp_valid_q <= 1'b0;
            err_q      <= '0;
            first_q    <= '0;
            mode_q     <= mode;
        end else begin
            if (addr_accept) begin
                if (!last_word) begin
                    idx_q  <= idx_q + 1'b1;
                    addr_q <= addr_q + STEP;
                end
                dp_valid_q <= 1'b1;
                dp_write_q <= (state_q == ST_WRITE);
                dp_addr_q  <= addr_q;
                if (state_q == ST_WRITE) hwdata_q   <= pattern;
                else                     exp_data_q <= pattern;
            end else if (HREADY) begin
                dp_valid_q <= 1'b0;
            end

            if (wflush_done) begin
                idx_q  <= '0;
                addr_q <= BASE_ADDR;
            end

            // The address is only recorded for the very first failure of the run.
            if (dp_done && dp_bad) begin
                if (err_q != '1)  err_q   <= err_q + 1'b1;
                if (err_q == '0)  first_q <= dp_addr_q;
            end
        end
    end

    ahb_lite_pattern_gen #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .LFSR_SEED  (LFSR_SEED)
    ) u_pattern (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .restart (start_ok || wflush_done),
        .advance (addr_accept),
        .mode    (mode_q),
        .index   (idx_q[$clog2(DATA_WIDTH)-1:0]),
        .addr    (addr_q),
        .pattern (pattern)
    );

    always_comb begin
        busy           = (state_q != ST_IDLE) && (state_q != ST_DONE);
        done           = (state_q == ST_DONE);
        pass           = done && (err_q == '0);
        err_count      = err_q;
        first_err_addr = first_q;
        HADDR          = addr_q;
        HBURST         = HBURST_SINGLE;
        HSEL           = busy;
        HSIZE          = hsize_for(DATA_WIDTH);
        HTRANS         = addr_phase ? HTRANS_NONSEQ : HTRANS_IDLE;
        HWDATA         = hwdata_q;
        HWRITE         = (state_q == ST_WRITE) || (state_q == ST_WFLUSH);
        dbg_state      = state_q;
    end

endmodule

// File: tb/tb_ahb_lite_mem_tester.sv
// Directed bench for ahb_lite_mem_tester: a 4-word AHB-Lite slave model with
// wait states, read corruption and error responses, plus hand-computed expectations.
module tb_ahb_lite_mem_tester;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          HCLK;
    logic          HRESETn;
    logic          start;
    logic [1:0]    mode;
    logic          busy, done, pass;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_addr;
    logic [AW-1:0] HADDR;
    logic [2:0]    HBURST, HSIZE;
    logic          HSEL, HWRITE;
    logic [1:0]    HTRANS;
    logic [DW-1:0] HWDATA, HRDATA;
    logic          HREADY, HRESP;
    logic [2:0]    dbg_state;

    ahb_lite_mem_tester #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BASE_ADDR  (32'h0),
        .WORD_COUNT (4),
        .LFSR_SEED  (32'hACE1_1234),
        .ERR_WIDTH  (16)
    ) dut (
        .HCLK           (HCLK),
        .HRESETn        (HRESETn),
        .start          (start),
        .mode           (mode),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_count      (err_count),
        .first_err_addr (first_err_addr),
        .HADDR          (HADDR),
        .HBURST         (HBURST),
        .HSEL           (HSEL),
        .HSIZE          (HSIZE),
        .HTRANS         (HTRANS),
        .HWDATA         (HWDATA),
        .HWRITE         (HWRITE),
        .HRDATA         (HRDATA),
        .HREADY         (HREADY),
        .HRESP          (HRESP),
        .dbg_state      (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else             n_pass++;
    endtask

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];       // expected HWDATA per completed write
    logic [AW-1:0] addr_exp_q[$];  // expected HADDR per accepted address phase
    logic [DW-1:0] mem [4];
    int            n_accepted;

    function automatic logic [DW-1:0] exp_word(input logic [1:0] m, input int i);
        logic [DW-1:0] a;
        a = DW'(i * 4);
        case (m)
            2'd0: return a;
            2'd3: return ~a;
            2'd2: return DW'(1) << i;
            default: case (i)
                0:       return 32'hACE1_1234;
                1:       return 32'h5670_891A;
                2:       return 32'h2B38_448D;
                default: return 32'h95BC_2245;
            endcase
        endcase
    endfunction

    // ---------------- slave model ----------------
    int            cfg_waits   = 0;
    logic          cfg_err_en  = 1'b0;
    logic [AW-1:0] cfg_err_addr = '0;
    logic          cfg_cor_en  = 1'b0;
    logic [AW-1:0] cfg_cor_addr = '0;

    initial begin
        logic          dp_active, dp_write, dp_err, prev_ready;
        logic [AW-1:0] dp_addr, s_addr, prev_addr;
        logic [DW-1:0] s_wdata, prev_wdata;
        logic [1:0]    s_trans, prev_trans;
        logic          s_write, s_sel;
        int            wait_left;
        dp_active = 1'b0; dp_write = 1'b0; dp_err = 1'b0; prev_ready = 1'b1;
        dp_addr = '0; prev_addr = '0; prev_wdata = '0; prev_trans = 2'b00;
        wait_left = 0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        forever begin
            @(negedge HCLK);
            s_trans = HTRANS; s_addr = HADDR; s_write = HWRITE; s_wdata = HWDATA; s_sel = HSEL;
            if (!HRESETn) begin
                prev_ready = 1'b1;
            end else begin
                if (!prev_ready && prev_trans == 2'b10) begin
                    check("hold_haddr", s_addr, prev_addr);
                    check("hold_htrans", s_trans, prev_trans);
                end
                if (!prev_ready && dp_active && dp_write) check("hold_hwdata", s_wdata, prev_wdata);
                prev_ready = HREADY; prev_addr = s_addr; prev_trans = s_trans; prev_wdata = s_wdata;
            end
            @(posedge HCLK);
            #1;
            if (!HRESETn) begin
                dp_active = 1'b0; wait_left = 0;
                HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
                continue;
            end
            if (HREADY) begin
                if (dp_active && dp_write) begin
                    mem[dp_addr[3:2]] = s_wdata;
                    if (exp_q.size() > 0) check("hwdata", s_wdata, exp_q.pop_front());
                end
                dp_active = (s_trans == 2'b10);
                if (dp_active) begin
                    check("hsel", s_sel, 1'b1);
                    check("hwrite", s_write, n_accepted < 4);
                    if (addr_exp_q.size() > 0) check("haddr", s_addr, addr_exp_q.pop_front());
                    n_accepted++;
                    dp_addr   = s_addr;
                    dp_write  = s_write;
                    dp_err    = cfg_err_en && s_write && (s_addr == cfg_err_addr);
                    wait_left = (dp_err && cfg_waits == 0) ? 1 : cfg_waits;
                end
            end
            if (dp_active && wait_left > 0) begin
                HREADY = 1'b0;
                HRESP  = dp_err && (wait_left == 1);
                wait_left--;
            end else begin
                HREADY = 1'b1;
                HRESP  = dp_active && dp_err;
            end
            HRDATA = (dp_active && !dp_write)
                   ? (mem[dp_addr[3:2]] ^ DW'((cfg_cor_en && dp_addr == cfg_cor_addr) ? 1 : 0))
                   : '0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_run(input logic [1:0] m);
        exp_q.delete();
        addr_exp_q.delete();
        n_accepted = 0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(exp_word(m, i));
            addr_exp_q.push_back(AW'(i * 4));
        end
        for (int i = 0; i < 4; i++) addr_exp_q.push_back(AW'(i * 4));
        @(posedge HCLK);
        #1;
        start = 1'b1;
        mode  = m;
        @(posedge HCLK);
        #1;
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        check("done_after_start", done, 1'b0);
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 300) begin
            @(posedge HCLK);
            #1;
            cycles++;
        end
        if (!done) check("done_timeout", done, 1'b1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cyc;
        HRESETn = 1'b0;
        start   = 1'b0;
        mode    = 2'd0;
        for (int i = 0; i < 4; i++) mem[i] = '0;
        repeat (3) @(posedge HCLK);
        #1;
        check("rst_htrans", HTRANS, 2'b00);
        check("rst_hsel", HSEL, 1'b0);
        check("rst_hwrite", HWRITE, 1'b0);
        check("rst_haddr", HADDR, 32'h0);
        check("rst_hwdata", HWDATA, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_err", err_count, 16'h0);
        check("rst_first", first_err_addr, 32'h0);
        check("rst_hburst", HBURST, 3'b000);
        check("rst_hsize", HSIZE, 3'b010);
        @(negedge HCLK);
        HRESETn = 1'b1;

        // zero-wait, address pattern
        start_run(2'd0);
        wait_done(cyc);
        check("t1_cycles", cyc, 10);
        check("t1_pass", pass, 1'b1);
        check("t1_err", err_count, 16'h0);
        check("t1_first", first_err_addr, 32'h0);
        check("t1_accepted", n_accepted, 8);
        check("t1_addr_drained", addr_exp_q.size(), 0);
        check("t1_mem3", mem[3], 32'hC);
        check("t1_htrans_idle", HTRANS, 2'b00);

        // two wait states per transfer, LFSR pattern
        cfg_waits = 2;
        start_run(2'd1);
        wait_done(cyc);
        check("t2_pass", pass, 1'b1);
        check("t2_err", err_count, 16'h0);
        check("t2_mem1", mem[1], 32'h5670_891A);
        check("t2_mem3", mem[3], 32'h95BC_2245);
        check("t2_accepted", n_accepted, 8);
        cfg_waits = 0;

        // read of 0x8 comes back with bit 0 flipped, walking-one pattern
        cfg_cor_en = 1'b1; cfg_cor_addr = 32'h8;
        start_run(2'd2);
        wait_done(cyc);
        check("t3_err", err_count, 16'h1);
        check("t3_first", first_err_addr, 32'h8);
        check("t3_pass", pass, 1'b0);
        check("t3_done", done, 1'b1);
        check("t3_mem2", mem[2], 32'h4);
        cfg_cor_en = 1'b0;

        // two-cycle ERROR response on the write to 0x4
        cfg_err_en = 1'b1; cfg_err_addr = 32'h4;
        start_run(2'd0);
        wait_done(cyc);
        check("t4_err", err_count, 16'h1);
        check("t4_first", first_err_addr, 32'h4);
        check("t4_pass", pass, 1'b0);
        check("t4_accepted", n_accepted, 8);
        check("t4_cycles", cyc, 11);
        cfg_err_en = 1'b0;

        // reset in the middle of the read pass, then a clean rerun
        start_run(2'd3);
        cyc = 0;
        while (!(HTRANS == 2'b10 && !HWRITE) && cyc < 100) begin
            @(posedge HCLK);
            #1;
            cyc++;
        end
        check("t5_reached_read", HWRITE, 1'b0);
        @(posedge HCLK);
        #2;
        HRESETn = 1'b0;
        #1;
        check("t5_rst_htrans", HTRANS, 2'b00);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_hsel", HSEL, 1'b0);
        check("t5_rst_err", err_count, 16'h0);
        check("t5_rst_first", first_err_addr, 32'h0);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        start_run(2'd3);
        wait_done(cyc);
        check("t5_cycles", cyc, 10);
        check("t5_pass", pass, 1'b1);
        check("t5_err", err_count, 16'h0);
        check("t5_mem1", mem[1], 32'hFFFF_FFFB);

        repeat (2) @(posedge HCLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ahb_lite_mem_tester.md
Name: ahb_lite_mem_tester

Overview:
- Synthesizable AHB-Lite single-master traffic generator and checker for on-board SDRAM/memory bring-up.
- Write pass: fills WORD_COUNT words from BASE_ADDR with a selectable data pattern.
- Read pass: reads the same words back, regenerates the expected pattern and compares it against the read data.
- Drives an AHB-Lite slave such as ahb_lite_sdram directly. Uses fully pipelined NONSEQ single transfers, tolerates HREADY wait states, and reports pass/fail, error count and first failing address.

Parameters:
- ADDR_WIDTH, 32, HADDR width.
- DATA_WIDTH, 32, HWDATA/HRDATA width; one of 8/16/32/64.
- BASE_ADDR, 0, byte address of the first word; DATA_WIDTH/8-aligned.
- WORD_COUNT, 1024, words per pass; range 1..2^20.
- LFSR_SEED, 32'hACE1_1234, nonzero seed for mode 1, truncated/replicated to DATA_WIDTH.
- ERR_WIDTH, 16, error counter width.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  async active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE or DONE.
- mode  in  2  pattern: 0 = address, 1 = LFSR, 2 = walking-one, 3 = ~address; latched on start.
- busy  out  1  high from the cycle after start until DONE.
- done  out  1  high in DONE; held until the next start.
- pass  out  1  done && err_count==0.
- err_count  out  ERR_WIDTH  mismatches + HRESP errors; saturating.
- first_err_addr  out  ADDR_WIDTH  HADDR of the first failing transfer; 0 if none.
- HADDR  out  ADDR_WIDTH  address phase.
- HBURST  out  3  constant 3'b000 (SINGLE).
- HSEL  out  1  high while busy.
- HSIZE  out  3  constant log2(DATA_WIDTH/8).
- HTRANS  out  2  IDLE 2'b00 / NONSEQ 2'b10 only.
- HWDATA  out  DATA_WIDTH  write data phase.
- HWRITE  out  1  high in write pass.
- HRDATA  in  DATA_WIDTH  read data.
- HREADY  in  1  transfer completion / phase advance.
- HRESP  in  1  1 = ERROR.

Behaviour:
- Reset (async, immediate):
  - State IDLE.
  - Outputs 0: HTRANS, HSEL, HWRITE, HADDR, HWDATA, busy, done, pass, err_count, first_err_addr.
  - Constant outputs: HBURST=0; HSIZE is constant.
  - Reset mid-pass abandons the pass; no completion of the in-flight transfer.
- FSM:
  - IDLE/DONE -start-> WRITE.
  - WRITE -> WFLUSH after the last address phase is accepted.
  - WFLUSH -> READ when the last write data phase completes (HREADY=1).
  - READ -> RFLUSH after the last address phase is accepted.
  - RFLUSH -> DONE when the last read data phase completes.
  - start is ignored in WRITE/WFLUSH/READ/RFLUSH.
- Start clears err_count and first_err_addr and restarts the pattern generator.
- Address phase:
  - In WRITE/READ, HTRANS=NONSEQ with HADDR = BASE_ADDR + i*(DATA_WIDTH/8).
  - Index i advances only on cycles with HREADY=1.
  - HADDR/HTRANS/HWRITE are held stable while HREADY=0.
  - HTRANS=IDLE in WFLUSH/RFLUSH/IDLE/DONE.
- Pipelining: the address phase of word i+1 overlaps the data phase of word i. One transfer per cycle at zero wait states. 2*WORD_COUNT+2 cycles from start to done.
- Write data: HWDATA = pattern(i) in the cycle after address i is accepted, held until HREADY=1.
- Read check:
  - On the read data-phase cycle with HREADY=1, compare HRDATA with expected(i).
  - On mismatch, or HRESP=1 on a completing cycle, err_count+1 (saturating at all-ones).
  - first_err_addr is captured only if err_count was 0.
- HRESP during write: counted the same way. The master never cancels; the sequence continues.
- Pattern rules:
  - Mode 0: address value truncated/zero-extended to DATA_WIDTH.
  - Mode 3: bitwise inverse of mode 0.
  - Mode 2: 1 << (i mod DATA_WIDTH).
  - Mode 1: Galois LFSR (maximal taps per width) stepped once per word from LFSR_SEED. The read pass reloads the seed, so it produces an identical sequence.
- Wrap: the address does not wrap; a BASE_ADDR/WORD_COUNT combination overflowing ADDR_WIDTH is illegal (elaboration assertion).
- WORD_COUNT=1: WRITE lasts one accepted address phase, then straight to WFLUSH.
- Simultaneous start and DONE: a new run begins and done falls the next cycle.

Decomposition:
- Shared package ahb_lite_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ.
  - HBURST_SINGLE.
  - HSIZE encodings.
  - HRESP_OKAY/ERROR.
  - Tester mode constants.
  - LFSR tap table per DATA_WIDTH.
- Sub-module ahb_lite_pattern_gen (DATA_WIDTH, LFSR_SEED):
  - Inputs: restart, advance, mode, index, addr.
  - Output: pattern; combinational from registered LFSR/index state.
  - Instantiated once; shared by both passes.

Test Plan:
- Zero-wait slave, DATA_WIDTH=32, WORD_COUNT=4, mode 0 -> HADDR 0,4,8,C NONSEQ on consecutive cycles; HWDATA 0,4,8,C; done 10 cycles after start; pass=1, err_count=0.
- HREADY low 2 cycles on each transfer, mode 1 -> address/data held stable during waits; read data equals the written LFSR sequence; pass=1.
- Slave corrupts word at 0x8 (bit 0 flipped), mode 2 -> err_count=1, first_err_addr=0x8, pass=0.
- HRESP ERROR (2-cycle response) on the write to 0x4 -> err_count=1, first_err_addr=0x4; remaining transfers still issued.
- HRESETn asserted mid READ -> HTRANS=IDLE, busy=0, counters 0 immediately; a new start runs cleanly to pass=1.
- With ahb_lite_sdram plus SDRAM model, WORD_COUNT=256, mode 3, across an auto-refresh -> pass=1, err_count=0.
